// File: rtl/clock_pkg.sv
// Shared constants for the HH:MM:SS BCD time-of-day counter.
// Limits are stored as BCD tens/ones pairs.
package clock_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] SEC_MAX_T  = 4'd5;
  localparam logic [DIGIT_W-1:0] SEC_MAX_O  = 4'd9;
  localparam logic [DIGIT_W-1:0] MIN_MAX_T  = 4'd5;
  localparam logic [DIGIT_W-1:0] MIN_MAX_O  = 4'd9;
  localparam logic [DIGIT_W-1:0] HOUR_MAX_T = 4'd2;
  localparam logic [DIGIT_W-1:0] HOUR_MAX_O = 4'd3;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps to 00 after TENS_MAX:ONES_MAX_AT_TENS_MAX.
// CLR has priority over EN; CARRY_OUT flags the wrapping step.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] TENS_MAX             = 4'd5,
  parameter logic [DIGIT_W-1:0] ONES_MAX_AT_TENS_MAX = 4'd9
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CLR,
  input  logic               EN,
  output logic               CARRY_OUT,
  output logic [DIGIT_W-1:0] TENS,
  output logic [DIGIT_W-1:0] ONES
);

  logic [DIGIT_W-1:0] tens_q, tens_d;
  logic [DIGIT_W-1:0] ones_q, ones_d;
  logic               at_max;

  assign at_max = (tens_q == TENS_MAX) &&
                  (ones_q == ONES_MAX_AT_TENS_MAX);

  assign CARRY_OUT = EN & at_max;

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (CLR) begin
      tens_d = '0;
      ones_d = '0;
    end else if (EN) begin
      if (at_max) begin
        tens_d = '0;
        ones_d = '0;
      end else if (ones_q == 4'd9) begin
        tens_d = tens_q + 4'd1;
        ones_d = '0;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign TENS = tens_q;
  assign ONES = ones_q;

endmodule

// File: rtl/bcd_clock_counter.sv
// 24-hour BCD time-of-day counter with 1 Hz prescaler and a set mode
// in which the minutes and hours are stepped by synchronised buttons.
module bcd_clock_counter
  import clock_pkg::*;
#(
  parameter int DIV         = 50_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               SET,
  input  logic               INC_MIN,
  input  logic               INC_HOUR,
  output logic [DIGIT_W-1:0] SEC_L,
  output logic [DIGIT_W-1:0] SEC_H,
  output logic [DIGIT_W-1:0] MIN_L,
  output logic [DIGIT_W-1:0] MIN_H,
  output logic [DIGIT_W-1:0] HOUR_L,
  output logic [DIGIT_W-1:0] HOUR_H,
  output logic               SEC_TICK
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [SYNC_STAGES-1:0] set_sq, min_sq, hour_sq;
  logic                   min_prev_q, hour_prev_q;
  logic [PW-1:0]          presc_q, presc_d;
  logic                   tick_q;

  logic set_s, min_s, hour_s;
  logic min_edge, hour_edge;
  logic tick;
  logic sec_carry, min_carry;
  logic min_en, hour_en;

  assign set_s  = set_sq[SYNC_STAGES-1];
  assign min_s  = min_sq[SYNC_STAGES-1];
  assign hour_s = hour_sq[SYNC_STAGES-1];

  assign min_edge  = min_s & ~min_prev_q;
  assign hour_edge = hour_s & ~hour_prev_q;

  // A tick landing on the first set-mode cycle is dropped here.
  assign tick = ~set_s && (presc_q == PRE_LAST);

  always_comb begin
    presc_d = presc_q + 1'b1;
    if (set_s || tick) presc_d = '0;
  end

  assign min_en  = set_s ? min_edge  : sec_carry;
  assign hour_en = set_s ? hour_edge : min_carry;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      set_sq      <= '0;
      min_sq      <= '0;
      hour_sq     <= '0;
      min_prev_q  <= 1'b0;
      hour_prev_q <= 1'b0;
      presc_q     <= '0;
      tick_q      <= 1'b0;
    end else begin
      set_sq      <= {set_sq[SYNC_STAGES-2:0], SET};
      min_sq      <= {min_sq[SYNC_STAGES-2:0], INC_MIN};
      hour_sq     <= {hour_sq[SYNC_STAGES-2:0], INC_HOUR};
      min_prev_q  <= min_s;
      hour_prev_q <= hour_s;
      presc_q     <= presc_d;
      tick_q      <= tick;
    end
  end

  bcd_mod_counter #(
    .TENS_MAX             (SEC_MAX_T),
    .ONES_MAX_AT_TENS_MAX (SEC_MAX_O)
  ) u_sec (
    .CLK       (CLK),
    .RST       (RST),
    .CLR       (set_s),
    .EN        (tick),
    .CARRY_OUT (sec_carry),
    .TENS      (SEC_H),
    .ONES      (SEC_L)
  );

  bcd_mod_counter #(
    .TENS_MAX             (MIN_MAX_T),
    .ONES_MAX_AT_TENS_MAX (MIN_MAX_O)
  ) u_min (
    .CLK       (CLK),
    .RST       (RST),
    .CLR       (1'b0),
    .EN        (min_en),
    .CARRY_OUT (min_carry),
    .TENS      (MIN_H),
    .ONES      (MIN_L)
  );

  bcd_mod_counter #(
    .TENS_MAX             (HOUR_MAX_T),
    .ONES_MAX_AT_TENS_MAX (HOUR_MAX_O)
  ) u_hour (
    .CLK       (CLK),
    .RST       (RST),
    .CLR       (1'b0),
    .EN        (hour_en),
    .CARRY_OUT (),
    .TENS      (HOUR_H),
    .ONES      (HOUR_L)
  );

  assign SEC_TICK = tick_q;

endmodule

// File: tb/tb_bcd_clock_counter.sv
// Scoreboard bench: a seconds-of-day reference model predicts every
// cycle's digits and SEC_TICK; a monitor compares after each edge.
module tb_bcd_clock_counter;

  localparam int DIV = 4;
  localparam int SS  = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       SET = 1'b0;
  logic       INC_MIN = 1'b0;
  logic       INC_HOUR = 1'b0;
  logic [3:0] SEC_L, SEC_H, MIN_L, MIN_H, HOUR_L, HOUR_H;
  logic       SEC_TICK;

  bcd_clock_counter #(
    .DIV         (DIV),
    .SYNC_STAGES (SS)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .SET      (SET),
    .INC_MIN  (INC_MIN),
    .INC_HOUR (INC_HOUR),
    .SEC_L    (SEC_L),
    .SEC_H    (SEC_H),
    .MIN_L    (MIN_L),
    .MIN_H    (MIN_H),
    .HOUR_L   (HOUR_L),
    .HOUR_H   (HOUR_H),
    .SEC_TICK (SEC_TICK)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int h;
    int m;
    int s;
    bit tick;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // model state
  int m_h, m_m, m_s, m_pc;
  bit set_h[SS+2];
  bit im_h[SS+2];
  bit ih_h[SS+2];

  function automatic logic [24:0] pack(exp_t e);
    return {4'(e.h / 10), 4'(e.h % 10),
            4'(e.m / 10), 4'(e.m % 10),
            4'(e.s / 10), 4'(e.s % 10), e.tick};
  endfunction

  function automatic logic [24:0] actual();
    return {HOUR_H, HOUR_L, MIN_H, MIN_L,
            SEC_H, SEC_L, SEC_TICK};
  endfunction

  task automatic model_clear();
    m_h = 0; m_m = 0; m_s = 0; m_pc = 0;
    for (int i = 0; i < SS + 2; i++) begin
      set_h[i] = 0; im_h[i] = 0; ih_h[i] = 0;
    end
  endtask

  // Called at a negedge: drive, predict the next edge, wait a cycle.
  task automatic cyc(input bit s, input bit im, input bit ih);
    exp_t e;
    int   t;
    bit   eff_set, em, eh;
    SET = s; INC_MIN = im; INC_HOUR = ih;
    for (int i = SS + 1; i > 0; i--) begin
      set_h[i] = set_h[i-1];
      im_h[i]  = im_h[i-1];
      ih_h[i]  = ih_h[i-1];
    end
    set_h[0] = s; im_h[0] = im; ih_h[0] = ih;
    eff_set = set_h[SS];
    em = im_h[SS] && !im_h[SS+1];
    eh = ih_h[SS] && !ih_h[SS+1];
    e.tick = 0;
    if (eff_set) begin
      m_s = 0;
      m_pc = 0;
      if (em) m_m = (m_m + 1) % 60;
      if (eh) m_h = (m_h + 1) % 24;
    end else if (m_pc == DIV - 1) begin
      m_pc = 0;
      t = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
      m_h = t / 3600;
      m_m = (t / 60) % 60;
      m_s = t % 60;
      e.tick = 1;
    end else begin
      m_pc++;
    end
    e.h = m_h; e.m = m_m; e.s = m_s;
    q.push_back(e);
    @(negedge CLK);
  endtask

  task automatic run(input int n, input bit s);
    for (int i = 0; i < n; i++) cyc(s, 0, 0);
  endtask

  task automatic pulses(input int n, input bit im, input bit ih);
    for (int i = 0; i < n; i++) begin
      cyc(1, im, ih);
      cyc(1, 0, 0);
    end
  endtask

  task automatic check_zero(input string name);
    n_cmp++;
    if (actual() !== 25'd0) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, actual(), 25'd0);
    end
  endtask

  // Called at a negedge; reset is raised mid-cycle, between edges.
  task automatic do_reset(input bit hold_set);
    #2 RST = 1'b1;
    #1 check_zero("async_reset");
    @(negedge CLK);
    check_zero("reset_hold");
    RST = 1'b0;
    SET = hold_set;
    model_clear();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (actual() !== pack(e)) begin
          n_bad++;
          $display("FAIL cycle @%0t: got %h want %h",
                   $time, actual(), pack(e));
        end
      end
    end
  end

  initial begin : stim
    bit s;
    model_clear();
    #1 check_zero("reset_initial");
    @(negedge CLK);
    check_zero("reset_state");
    RST = 1'b0;

    // free-running seconds from reset
    run(20, 0);

    // set 23:59, then run through the midnight wrap
    run(3, 1);
    pulses(23, 0, 1);
    pulses(59, 1, 0);
    run(59 * DIV + 2 * DIV + 3, 0);

    // reach 12:34:27 and freeze in set mode
    pulses(12, 0, 1);
    pulses(34, 1, 0);
    run(3, 1);
    run(27 * DIV + 1, 0);
    run(40, 1);

    // 05:59, minute wrap without hour carry, hour wrap, held button
    pulses(17, 0, 1);
    pulses(25, 1, 0);
    pulses(1, 1, 0);
    pulses(19, 0, 1);
    for (int i = 0; i < 50; i++) cyc(1, 0, 1);
    run(4, 1);

    // simultaneous buttons from 10:10 in set and run mode
    pulses(9, 0, 1);
    pulses(10, 1, 0);
    pulses(1, 1, 1);
    run(4, 1);
    run(10, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 1);
      cyc(0, 0, 0);
    end
    run(13, 0);

    // async reset in run mode, then first tick timing
    do_reset(0);
    run(3 * DIV + 2, 0);

    // randomized mode toggling and button chatter
    s = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0) s = ~s;
      cyc(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // reset while in set mode
    run(5, 1);
    do_reset(0);
    run(2 * DIV + 3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
